// File: rtl/psram_responder.sv
`default_nettype none
// =============================================================================
// psram_responder : device-side PSRAM bus model with an internal byte array
// Revision 1.0 - initial release
// =============================================================================
module psram_responder #(
    parameter int         ADDR_W      = 12,
    parameter int         LATENCY     = 4,
    parameter logic [7:0] CMD_READ    = 8'h03,
    parameter logic [7:0] CMD_WRITE   = 8'h02,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clkSys,
    input  logic       rst,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_psram_data,
    output logic [7:0] o_psram_data,
    output logic       o_psram_oe,
    output logic       o_busy,
    output logic [7:0] o_cmdErrors
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RLAT, S_RDATA, S_IGNORE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t                              state_q, state_d;
    logic [SYNC_STAGES-1:0]              sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]              cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][7:0]         data_sync_q, data_sync_d;
    logic                                sclk_prev_q, sclk_prev_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic [1:0]                          byte_cnt_q, byte_cnt_d;
    logic                                is_write_q, is_write_d;
    logic [3:0]                          lat_cnt_q, lat_cnt_d;
    logic [7:0]                          rdata_q, rdata_d;
    logic                                oe_q, oe_d;
    logic [7:0]                          cmd_err_q, cmd_err_d;
    logic [7:0]                          mem_rd_q, mem_rd_d;

    logic [7:0]        mem [2**ADDR_W];
    logic              mem_we;
    logic              sclk_s, cs_s, rise, fall;
    logic [7:0]        data_s;
    logic [3:0]        lat_next;
    logic [ADDR_W-1:0] addr_shift;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign fall     = ~sclk_s & sclk_prev_q;
    assign lat_next = lat_cnt_q + 4'd1;

    // Address bytes arrive MSB first; only the low ADDR_W bits are kept.
    if (ADDR_W > 8) begin : g_addr_wide
        assign addr_shift = {addr_q[ADDR_W-9:0], data_s};
    end else begin : g_addr_narrow
        assign addr_shift = data_s[ADDR_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_psram_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_psram_cs};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i_psram_data};
        sclk_prev_d = sclk_s;
        addr_d      = addr_q;
        byte_cnt_d  = byte_cnt_q;
        is_write_d  = is_write_q;
        lat_cnt_d   = lat_cnt_q;
        rdata_d     = rdata_q;
        oe_d        = oe_q;
        cmd_err_d   = cmd_err_q;
        mem_rd_d    = mem[addr_q];
        mem_we      = 1'b0;

        if (cs_s) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_CMD;
                    byte_cnt_d = 2'd0;
                end
                S_CMD: if (rise) begin
                    if (data_s == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else if (data_s == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        if (cmd_err_q != 8'hFF) cmd_err_d = cmd_err_q + 8'd1;
                        state_d = S_IGNORE;
                    end
                end
                S_ADDR: if (rise) begin
                    addr_d     = addr_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd2) begin
                        lat_cnt_d = 4'd0;
                        if (is_write_q)        state_d = S_WDATA;
                        else if (LATENCY == 0) state_d = S_RDATA;
                        else                   state_d = S_RLAT;
                    end
                end
                S_WDATA: if (rise) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                end
                S_RLAT: if (rise) begin
                    lat_cnt_d = lat_next;
                    if (lat_next == 4'(LATENCY)) state_d = S_RDATA;
                end
                S_RDATA: if (fall) begin
                    // mem_rd_q was fetched from addr_q at least a cycle before this fall
                    rdata_d = mem_rd_q;
                    oe_d    = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            data_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            addr_q      <= '0;
            byte_cnt_q  <= 2'd0;
            is_write_q  <= 1'b0;
            lat_cnt_q   <= 4'd0;
            rdata_q     <= 8'd0;
            oe_q        <= 1'b0;
            cmd_err_q   <= 8'd0;
            mem_rd_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            data_sync_q <= data_sync_d;
            sclk_prev_q <= sclk_prev_d;
            addr_q      <= addr_d;
            byte_cnt_q  <= byte_cnt_d;
            is_write_q  <= is_write_d;
            lat_cnt_q   <= lat_cnt_d;
            rdata_q     <= rdata_d;
            oe_q        <= oe_d;
            cmd_err_q   <= cmd_err_d;
            mem_rd_q    <= mem_rd_d;
        end
    end

    always_ff @(posedge clkSys) begin
        if (mem_we) mem[addr_q] <= data_s;
    end

    // Gating with cs_s drops the bus driver in the same cycle cs is seen high.
    assign o_psram_data = rdata_q;
    assign o_psram_oe   = oe_q & ~cs_s;
    assign o_busy       = ~cs_s;
    assign o_cmdErrors  = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_responder.sv
`default_nettype none
// =============================================================================
// tb_psram_responder : directed bench for psram_responder (LATENCY 4 and 0)
// Revision 1.0 - initial release
// =============================================================================
module tb_psram_responder;

    localparam int HALF = 60;

    logic       clk;
    logic       rst;
    logic       cs, cs0;
    logic       sclk;
    logic [7:0] data;
    logic [7:0] o_data, o_data0;
    logic       o_oe, o_oe0, o_busy, o_busy0;
    logic [7:0] o_err, o_err0;

    int checks = 0;
    int errors = 0;

    psram_responder #(.LATENCY(4)) dut (
        .clkSys(clk), .rst(rst), .i_psram_cs(cs), .i_psram_sclk(sclk),
        .i_psram_data(data), .o_psram_data(o_data), .o_psram_oe(o_oe),
        .o_busy(o_busy), .o_cmdErrors(o_err)
    );

    psram_responder #(.LATENCY(0)) dut0 (
        .clkSys(clk), .rst(rst), .i_psram_cs(cs0), .i_psram_sclk(sclk),
        .i_psram_data(data), .o_psram_data(o_data0), .o_psram_oe(o_oe0),
        .o_busy(o_busy0), .o_cmdErrors(o_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_clk(input logic [7:0] d);
        data = d;
        #HALF sclk = 1'b1;
        #HALF sclk = 1'b0;
    endtask

    task automatic begin_txn(input bit use_dut0);
        if (use_dut0) cs0 = 1'b0;
        else          cs  = 1'b0;
        #HALF;
    endtask

    task automatic end_txn();
        #HALF;
        cs  = 1'b1;
        cs0 = 1'b1;
        #(2*HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        bus_clk(cmd);
        bus_clk(a[23:16]);
        bus_clk(a[15:8]);
        bus_clk(a[7:0]);
    endtask

    // Header plus four dummy clocks; returns HALF after the fall that drives byte 0.
    task automatic rd_first(input logic [23:0] a);
        send_hdr(8'h03, a);
        repeat (4) bus_clk(8'h00);
        #HALF;
    endtask

    initial begin
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;

        rst = 1'b0; cs = 1'b1; cs0 = 1'b1; sclk = 1'b0; data = 8'h00;
        #22;
        chk("rst_data", o_data, 8'h00);
        chk("rst_oe", o_oe, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_err, 8'h00);
        rst = 1'b1;
        #40;

        // single write then read with 4 dummy clocks
        begin_txn(0);
        chk("busy_active", o_busy, 1'b1);
        send_hdr(8'h02, 24'h000001);
        bus_clk(8'hAA);
        chk("wr_oe_low", o_oe, 1'b0);
        end_txn();
        begin_txn(0);
        send_hdr(8'h03, 24'h000001);
        repeat (3) bus_clk(8'h00);
        #HALF;
        chk("lat_not_early", o_oe, 1'b0);
        bus_clk(8'h00);
        #HALF;
        chk("t1_data", o_data, 8'hAA);
        chk("t1_oe", o_oe, 1'b1);
        end_txn();
        chk("idle_busy", o_busy, 1'b0);
        chk("idle_oe", o_oe, 1'b0);

        // burst write/read across the array wrap
        begin_txn(0);
        send_hdr(8'h02, 24'h000FFE);
        for (int i = 0; i < 4; i++) bus_clk(exp_b[i]);
        end_txn();
        begin_txn(0);
        rd_first(24'h000FFE);
        chk("t2_b0", o_data, exp_b[0]);
        for (int i = 1; i < 4; i++) begin
            bus_clk(8'h00);
            #HALF;
            chk("t2_burst", o_data, exp_b[i]);
        end
        end_txn();

        // unknown command
        begin_txn(0);
        bus_clk(8'h55);
        bus_clk(8'h00); bus_clk(8'h00); bus_clk(8'h01); bus_clk(8'hBB);
        #HALF;
        chk("t3_oe", o_oe, 1'b0);
        chk("t3_err", o_err, 8'h01);
        end_txn();
        begin_txn(0);
        rd_first(24'h000001);
        chk("t3_unchanged", o_data, 8'h44);
        end_txn();

        // aborted write after two address bytes
        begin_txn(0);
        bus_clk(8'h02); bus_clk(8'h00); bus_clk(8'h00);
        end_txn();
        begin_txn(0);
        send_hdr(8'h02, 24'h000010);
        bus_clk(8'h77);
        end_txn();
        begin_txn(0);
        rd_first(24'h000010);
        chk("t4_data", o_data, 8'h77);
        end_txn();
        begin_txn(0);
        rd_first(24'h000000);
        chk("t4_no_stray", o_data, 8'h33);
        end_txn();
        chk("t4_err", o_err, 8'h01);

        // reset in the middle of a read burst
        begin_txn(0);
        rd_first(24'h000FFE);
        chk("t5_pre_oe", o_oe, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_oe", o_oe, 1'b0);
        chk("t5_busy", o_busy, 1'b0);
        chk("t5_data", o_data, 8'h00);
        chk("t5_err", o_err, 8'h00);
        cs = 1'b1;
        #20 rst = 1'b1;
        #(2*HALF);
        begin_txn(0);
        rd_first(24'h000FFE);
        chk("t5_kept0", o_data, 8'h11);
        bus_clk(8'h00);
        #HALF;
        chk("t5_kept1", o_data, 8'h22);
        end_txn();

        // zero-latency build
        begin_txn(1);
        send_hdr(8'h02, 24'h000001);
        bus_clk(8'h5A);
        end_txn();
        begin_txn(1);
        bus_clk(8'h03); bus_clk(8'h00); bus_clk(8'h00);
        #HALF;
        chk("t6_oe_early", o_oe0, 1'b0);
        bus_clk(8'h01);
        #HALF;
        chk("t6_data", o_data0, 8'h5A);
        chk("t6_oe", o_oe0, 1'b1);
        chk("t6_main_idle", o_busy, 1'b0);
        end_txn();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
